decode_issue_ctrl: RTL and testbench
====================================

Name: decode_issue_ctrl

Overview:
- Fetch-to-decode handoff controller for the flintRV core.
- Accepts fetched instructions over a valid/ready handshake and buffers them in a 2-entry structure: one output register plus one skid entry.
- Drives the ImmGen datapath on the instruction entering the output register. The ImmGen result is registered alongside instruction and PC for the execute stage.
- Handles back-pressure, pipeline flush (branch/jump redirect) and counts stall cycles.

Parameters:
- XLEN, 32, PC width in bits.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all buffered instructions; highest priority after rst.
- f_valid  in  1  fetch presents an instruction.
- f_ready  out  1  controller can accept this cycle.
- f_instr  in  32  fetched instruction word, little-endian.
- f_pc  in  XLEN  PC of f_instr.
- d_valid  out  1  output register holds a valid instruction.
- d_ready  in  1  execute stage consumes this cycle.
- d_instr  out  32  registered instruction.
- d_pc  out  XLEN  registered PC.
- d_imm  out  32  registered sign-extended immediate from ImmGen.
- stall_cnt  out  CNT_W  saturating count of cycles with d_valid=1 and d_ready=0.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high.
- Reset values: d_valid=0, d_instr=0, d_pc=0, d_imm=0, skid entry empty, stall_cnt=0. f_ready=0 while rst=1, and f_ready=1 in the first cycle after rst deasserts.
- Handshake rules:
  - Input transfer occurs when f_valid && f_ready.
  - Output transfer occurs when d_valid && d_ready.
  - f_ready = !rst && !skid_valid. It is a registered signal with no combinational path from d_ready.
  - d_valid, d_instr, d_pc and d_imm are held stable while d_valid && !d_ready.
- Output register update condition: the register loads when !d_valid || d_ready.
  - If skid_valid: load from skid (instr, pc, ImmGen(skid_instr)) and clear skid. If an input transfer happens in the same cycle, it goes into skid.
  - Else, if an input transfer happens: load directly (latency 1 cycle, accept to d_valid).
  - Else: d_valid becomes 0 (payload registers may hold).
- Output register stalled (d_valid && !d_ready) with an input transfer: the input is written to skid. An input transfer cannot occur while skid is full, because f_ready=0.
- Ordering: strictly in order. Skid always drains before any newer instruction reaches the output register.
- ImmGen use:
  - One combinational ImmGen instance; its input is muxed between skid_instr and f_instr by the load source.
  - Formats by opcode[6:0]:
    - I: 0010011, 0000011, 1100111
    - S: 0100011
    - B: 1100011
    - U: 0110111, 0010111
    - J: 1101111
    - Any other opcode: imm=0.
- Flush:
  - Next cycle d_valid=0 and skid empty.
  - An input transfer in the same cycle as flush is discarded.
  - An output transfer in the same cycle as flush still counts as consumed.
  - stall_cnt is not affected by flush.
- Reset mid-operation: all buffered entries are dropped and state returns to reset values the next cycle.
- stall_cnt:
  - Increments by 1 each cycle with d_valid && !d_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by rst.
- Occupancy is 0..2. Throughput is 1 instruction per cycle when d_ready is held high.

Test Plan:
- Streaming: after reset, f_valid=1 with f_instr=0xFFF00093 (addi x1,x0,-1), f_pc=0x100, and d_ready=1 -> one cycle later d_valid=1, d_pc=0x100, d_imm=0xFFFFFFFF.
- Back-to-back formats: feed 0xFE112E23 (sw), 0x123452B7 (lui) and 0xFF9FF06F (jal x0,-8) on consecutive cycles with d_ready=1 -> d_imm is 0xFFFFFFFC, 0x12345000, 0xFFFFFFF8 on three consecutive cycles, in order.
- Back-pressure: d_ready=0 and send A (pc 0x0), then B (pc 0x4) -> f_ready=0 after B is accepted and stall_cnt increments every cycle. Raise d_ready -> A, then B, with no loss or duplication; f_ready returns to 1.
- Flush: with two entries buffered and f_valid=1 presenting C in the flush cycle -> the next cycle has d_valid=0 and f_ready=1, C is never output, and stall_cnt keeps its value.
- Saturation: CNT_W=4 with d_valid=1 and d_ready=0 for 20 cycles -> stall_cnt=15 and holds at 15.
- Reset mid-stall: assert rst with skid full -> the next cycle has d_valid=0, stall_cnt=0 and f_ready=0; f_ready=1 in the first cycle after rst deasserts.

Source files
------------

// File: rtl/decode_issue_ctrl.sv
// Fetch-to-decode handoff for flintRV: output register plus one skid entry,
// ImmGen on the loading instruction, flush handling and a stall-cycle counter.
`timescale 1ns/1ps

module decode_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             f_valid,
  output logic             f_ready,
  input  logic [31:0]      f_instr,
  input  logic [XLEN-1:0]  f_pc,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [31:0]      d_instr,
  output logic [XLEN-1:0]  d_pc,
  output logic [31:0]      d_imm,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [6:0] {
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_JALR   = 7'b1100111,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;

  logic        in_xfer;
  logic        load_en;
  logic        stalled;
  logic [31:0] imm_src;
  logic [31:0] imm_val;

  // f_ready depends only on the skid register and rst, never on d_ready.
  assign f_ready = !rst && !skid_valid;
  assign in_xfer = f_valid && f_ready;
  assign load_en = !d_valid || d_ready;
  assign stalled = d_valid && !d_ready;

  // The skid entry is always older than f_instr, so it wins the ImmGen mux.
  assign imm_src = skid_valid ? skid_instr : f_instr;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    imm_val = '0;
    case (imm_src[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        imm_val = {{20{imm_src[31]}}, imm_src[31:20]};
      OP_STORE:
        imm_val = {{20{imm_src[31]}}, imm_src[31:25], imm_src[11:7]};
      OP_BRANCH:
        imm_val = {{19{imm_src[31]}}, imm_src[31], imm_src[7],
                   imm_src[30:25], imm_src[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_val = {imm_src[31:12], 12'b0};
      OP_JAL:
        imm_val = {{11{imm_src[31]}}, imm_src[31], imm_src[19:12],
                   imm_src[20], imm_src[30:21], 1'b0};
      default:
        imm_val = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload registers are reset too because their reset value is
      // architecturally visible on d_instr/d_pc/d_imm.
      d_valid    <= 1'b0;
      d_instr    <= '0;
      d_pc       <= '0;
      d_imm      <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      d_valid    <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_en) begin
      if (skid_valid) begin
        d_valid    <= 1'b1;
        d_instr    <= skid_instr;
        d_pc       <= skid_pc;
        d_imm      <= imm_val;
        skid_valid <= in_xfer;
        if (in_xfer) begin
          skid_instr <= f_instr;
          skid_pc    <= f_pc;
        end
      end else if (in_xfer) begin
        d_valid <= 1'b1;
        d_instr <= f_instr;
        d_pc    <= f_pc;
        d_imm   <= imm_val;
      end else begin
        d_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_instr <= f_instr;
      skid_pc    <= f_pc;
    end
  end

  // Counter ignores flush; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
`timescale 1ns/1ps

module tb_decode_issue_ctrl;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, f_valid, d_ready;
  logic [31:0] f_instr, f_pc;

  logic        f_ready, d_valid;
  logic [31:0] d_instr, d_pc, d_imm;
  logic [15:0] stall16;

  logic        f_ready4, d_valid4;
  logic [31:0] d_instr4, d_pc4, d_imm4;
  logic [3:0]  stall4;

  decode_issue_ctrl #(.XLEN(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .f_valid(f_valid), .f_ready(f_ready), .f_instr(f_instr), .f_pc(f_pc),
    .d_valid(d_valid), .d_ready(d_ready), .d_instr(d_instr), .d_pc(d_pc),
    .d_imm(d_imm), .stall_cnt(stall16)
  );

  decode_issue_ctrl #(.XLEN(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .f_valid(f_valid), .f_ready(f_ready4), .f_instr(f_instr), .f_pc(f_pc),
    .d_valid(d_valid4), .d_ready(d_ready), .d_instr(d_instr4), .d_pc(d_pc4),
    .d_imm(d_imm4), .stall_cnt(stall4)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: in-order queue of buffered entries plus stall counters.
  entry_t q[$];
  int     m_stall16;
  int     m_stall4;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Immediate computed arithmetically from the ISA field definitions.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int sw;
    int r;
    sw = int'(w);
    r  = 0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: r = sw >>> 20;
      7'h23: r = (sw >>> 25) * 32 + int'(w[11:7]);
      7'h63: r = (sw >>> 31) * 4096 + int'(w[7]) * 2048
                 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      7'h37, 7'h17: r = int'(w & 32'hFFFF_F000);
      7'h6F: r = (sw >>> 31) * 1048576 + int'(w[19:12]) * 4096
                 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      default: r = 0;
    endcase
    return 32'(r);
  endfunction

  task automatic check_all();
    logic exp_fr;
    exp_fr = !rst && (q.size() < 2);
    check("f_ready", f_ready, exp_fr);
    check("f_ready_w4", f_ready4, exp_fr);
    check("d_valid", d_valid, q.size() > 0);
    check("d_valid_w4", d_valid4, q.size() > 0);
    check("stall_cnt16", stall16, m_stall16);
    check("stall_cnt4", stall4, m_stall4);
    if (q.size() > 0) begin
      check("d_instr", d_instr, q[0].instr);
      check("d_pc", d_pc, q[0].pc);
      check("d_imm", d_imm, ref_imm(q[0].instr));
      check("d_instr_w4", d_instr4, q[0].instr);
      check("d_pc_w4", d_pc4, q[0].pc);
      check("d_imm_w4", d_imm4, ref_imm(q[0].instr));
    end
  endtask

  task automatic model_update();
    logic acc;
    if (rst) begin
      q.delete();
      m_stall16 = 0;
      m_stall4  = 0;
    end else begin
      acc = f_valid && (q.size() < 2);
      if (q.size() > 0 && !d_ready) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && d_ready) void'(q.pop_front());
        if (acc) q.push_back('{f_instr, f_pc});
      end
    end
  endtask

  // Called at a falling edge: drive, check, let one rising edge pass.
  task automatic step(input logic r, input logic fl, input logic fv,
                      input logic [31:0] fi, input logic [31:0] fp, input logic dr);
    rst = r; flush = fl; f_valid = fv; f_instr = fi; f_pc = fp; d_ready = dr;
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] opcodes [9];
    int          saved_stall;
    logic [31:0] w;

    opcodes = '{32'h13, 32'h03, 32'h67, 32'h23, 32'h63, 32'h37, 32'h17, 32'h6F, 32'h33};

    rst = 1'b1; flush = 1'b0; f_valid = 1'b0; f_instr = '0; f_pc = '0; d_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q.delete();
    m_stall16 = 0;
    m_stall4  = 0;

    // Reset state
    step(1, 0, 0, 32'h0, 32'h0, 0);
    check("rst_d_instr", d_instr, 32'h0);
    check("rst_d_pc", d_pc, 32'h0);
    check("rst_d_imm", d_imm, 32'h0);

    // Streaming: addi x1,x0,-1 at 0x100
    step(0, 0, 1, 32'hFFF0_0093, 32'h100, 1);
    check("stream_valid", d_valid, 1'b1);
    check("stream_pc", d_pc, 32'h100);
    check("stream_imm", d_imm, 32'hFFFF_FFFF);

    // Back-to-back formats: sw, lui, jal
    step(0, 0, 1, 32'hFE11_2E23, 32'h104, 1);
    check("b2b_sw_imm", d_imm, 32'hFFFF_FFFC);
    step(0, 0, 1, 32'h1234_52B7, 32'h108, 1);
    check("b2b_lui_imm", d_imm, 32'h1234_5000);
    step(0, 0, 1, 32'hFF9F_F06F, 32'h10C, 1);
    check("b2b_jal_imm", d_imm, 32'hFFFF_FFF8);
    step(0, 0, 0, 32'h0, 32'h0, 1);
    check("b2b_drained", d_valid, 1'b0);

    // Back-pressure: A then B with d_ready low
    step(0, 0, 1, 32'h0050_0113, 32'h0, 0);
    step(0, 0, 1, 32'h0000_0263, 32'h4, 0);
    check("bp_f_ready_low", f_ready, 1'b0);
    check("bp_head_pc", d_pc, 32'h0);
    repeat (3) step(0, 0, 0, 32'h0, 32'h0, 0);
    check("bp_stall_cnt", stall16, 16'd4);
    step(0, 0, 0, 32'h0, 32'h0, 1);
    check("bp_second_valid", d_valid, 1'b1);
    check("bp_second_pc", d_pc, 32'h4);
    check("bp_f_ready_back", f_ready, 1'b1);
    step(0, 0, 0, 32'h0, 32'h0, 1);
    check("bp_empty", d_valid, 1'b0);

    // Flush with two entries buffered, C presented in the flush cycle
    step(0, 0, 1, 32'h0010_0093, 32'h200, 0);
    step(0, 0, 1, 32'h0020_0093, 32'h204, 0);
    saved_stall = m_stall16;
    step(0, 1, 1, 32'h0030_0093, 32'h208, 1);
    check("flush_d_valid", d_valid, 1'b0);
    check("flush_f_ready", f_ready, 1'b1);
    check("flush_stall_kept", stall16, saved_stall);
    repeat (3) step(0, 0, 0, 32'h0, 32'h0, 1);

    // Saturation of the 4-bit counter
    step(1, 0, 0, 32'h0, 32'h0, 0);
    step(0, 0, 1, 32'h0040_0093, 32'h300, 0);
    repeat (20) step(0, 0, 0, 32'h0, 32'h0, 0);
    check("sat_cnt4", stall4, 4'd15);
    check("sat_cnt16", stall16, 16'd20);
    repeat (5) step(0, 0, 0, 32'h0, 32'h0, 0);
    check("sat_cnt4_hold", stall4, 4'd15);
    check("sat_cnt16_more", stall16, 16'd25);

    // Reset mid-stall with skid full
    step(0, 0, 1, 32'h0050_0093, 32'h304, 0);
    step(1, 0, 0, 32'h0, 32'h0, 0);
    check("rst_mid_d_valid", d_valid, 1'b0);
    check("rst_mid_stall", stall16, 16'd0);
    check("rst_mid_f_ready", f_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_release_f_ready", f_ready, 1'b1);
    step(0, 0, 0, 32'h0, 32'h0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      w = $urandom();
      w[6:0] = opcodes[$urandom_range(8)][6:0];
      step(($urandom_range(99) == 0), ($urandom_range(24) == 0),
           ($urandom_range(3) != 0), w, $urandom() & 32'hFFFF_FFFC,
           ($urandom_range(2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
